// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution; optional return-address stack under `define PC_RAS_EN.
// Latency: step accepted at edge k, pc/link/stack written at edge k+2, done pulses k+2..k+3.
// Backpressure: ready=0 from edge k until edge k+3; step while not ready is dropped, never queued.
module pc_branch_unit #(
   parameter int ADDR_W    = 9,
   parameter int IMM_W     = 8,
   parameter int RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              step,
   input  logic              br_valid,
   input  logic [1:0]        br_kind,
   input  logic [2:0]        cond,
   input  logic              N,
   input  logic              V,
   input  logic              Z,
   input  logic [IMM_W-1:0]  imm,
   input  logic [ADDR_W-1:0] reg_target,
   input  logic              clr_flags,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] link,
   output logic              ready,
   output logic              done,
   output logic              taken,
   output logic              ras_ovf,
   output logic              ras_unf
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_RESOLVE, S_COMMIT, S_DONE} state_t;

   state_t            state_q;
   logic              ready_q, done_q, taken_q;
   logic [ADDR_W-1:0] pc_q, link_q;

   // operands captured when step is accepted
   logic              brv_q, n_q, v_q, z_q;
   logic [1:0]        kind_q;
   logic [2:0]        cond_q;
   logic [IMM_W-1:0]  imm_q;
   logic [ADDR_W-1:0] rtgt_q;

   // resolution results held for the commit cycle
   logic [ADDR_W-1:0] tgt_q;
   logic              tkn_q, push_q, pop_q;

   logic [ADDR_W-1:0] seq, rel, tgt_d;
   logic              cond_ok, tkn_d, push_d, pop_d;
   logic              ras_has;
   logic [ADDR_W-1:0] ras_top;
   logic              commit;

   assign commit = (state_q == S_COMMIT);
   assign seq    = pc_q + ONE;
   assign rel    = seq + {{(ADDR_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

   // condition code evaluation against the captured flags
   always_comb begin
      cond_ok = 1'b0;
      case (cond_q)
         3'b000:  cond_ok = 1'b1;
         3'b001:  cond_ok = z_q;
         3'b010:  cond_ok = ~z_q;
         3'b011:  cond_ok = n_q ^ v_q;
         3'b100:  cond_ok = z_q | (n_q ^ v_q);
         default: cond_ok = 1'b0;
      endcase
   end

   // next-pc selection; stack is stable here since it only changes at commit
   always_comb begin
      tgt_d  = seq;
      tkn_d  = 1'b0;
      push_d = 1'b0;
      pop_d  = 1'b0;
      if (brv_q) begin
         case (kind_q)
            2'b00: begin
               if (cond_ok) begin
                  tgt_d = rel;
                  tkn_d = 1'b1;
               end
            end
            2'b01: begin
               tgt_d  = rel;
               tkn_d  = 1'b1;
               push_d = 1'b1;
            end
            2'b10: begin
               tgt_d = ras_has ? ras_top : rtgt_q;
               tkn_d = 1'b1;
               pop_d = 1'b1;
            end
            default: begin
               tgt_d  = rtgt_q;
               tkn_d  = 1'b1;
               push_d = 1'b1;
            end
         endcase
      end
   end

   // sequencer: capture, resolve, commit, done pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         taken_q <= 1'b0;
         pc_q    <= '0;
         link_q  <= '0;
         brv_q   <= 1'b0;
         kind_q  <= '0;
         cond_q  <= '0;
         n_q     <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
         imm_q   <= '0;
         rtgt_q  <= '0;
         tgt_q   <= '0;
         tkn_q   <= 1'b0;
         push_q  <= 1'b0;
         pop_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (step) begin
                  brv_q   <= br_valid;
                  kind_q  <= br_kind;
                  cond_q  <= cond;
                  n_q     <= N;
                  v_q     <= V;
                  z_q     <= Z;
                  imm_q   <= imm;
                  rtgt_q  <= reg_target;
                  ready_q <= 1'b0;
                  state_q <= S_RESOLVE;
               end
            end
            S_RESOLVE: begin
               tgt_q   <= tgt_d;
               tkn_q   <= tkn_d;
               push_q  <= push_d;
               pop_q   <= pop_d;
               state_q <= S_COMMIT;
            end
            S_COMMIT: begin
               pc_q <= tgt_q;
               if (push_q) link_q <= seq;
               done_q  <= 1'b1;
               taken_q <= tkn_q;
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               taken_q <= 1'b0;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pc    = pc_q;
   assign link  = link_q;
   assign ready = ready_q;
   assign done  = done_q;
   assign taken = taken_q;

`ifdef PC_RAS_EN
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);

   logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
   logic [PTR_W-1:0]  top_q;
   logic [PTR_W:0]    cnt_q;
   logic              ovf_q, unf_q, ovf_ev, unf_ev;

   assign ras_has = (cnt_q != '0);
   assign ras_top = ras_mem_q[top_q - 1'b1];
   assign ovf_ev  = commit & push_q & (cnt_q == FULL);
   assign unf_ev  = commit & pop_q & ~ras_has;

   // storage; writing at top when full lands on the oldest entry
   always_ff @(posedge clk) begin
      if (commit && push_q) ras_mem_q[top_q] <= seq;
   end

   // stack pointer, occupancy and sticky flags (a set event beats clr_flags)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         top_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (commit && push_q) begin
            top_q <= top_q + 1'b1;
            if (cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
         end else if (commit && pop_q && ras_has) begin
            top_q <= top_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
         end
         if (ovf_ev)         ovf_q <= 1'b1;
         else if (clr_flags) ovf_q <= 1'b0;
         if (unf_ev)         unf_q <= 1'b1;
         else if (clr_flags) unf_q <= 1'b0;
      end
   end

   assign ras_ovf = ovf_q;
   assign ras_unf = unf_q;
`else
   logic unused_cfg;

   assign ras_has    = 1'b0;
   assign ras_top    = '0;
   assign ras_ovf    = 1'b0;
   assign ras_unf    = 1'b0;
   assign unused_cfg = clr_flags ^ pop_q ^ commit;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboarded bench for pc_branch_unit: directed scenarios plus random traffic.
// Expected results come from a queue-based model of the branch rules.
// A monitor pops one expectation per done pulse and checks timing and outputs.
module tb_pc_branch_unit;

   localparam int ADDR_W    = 9;
   localparam int IMM_W     = 8;
   localparam int RAS_DEPTH = 4;
   localparam int MASK      = (1 << ADDR_W) - 1;
`ifdef PC_RAS_EN
   localparam bit RAS = 1'b1;
`else
   localparam bit RAS = 1'b0;
`endif

   logic              clk, reset, step, br_valid, N, V, Z, clr_flags;
   logic [1:0]        br_kind;
   logic [2:0]        cond;
   logic [IMM_W-1:0]  imm;
   logic [ADDR_W-1:0] reg_target, pc, link;
   logic              ready, done, taken, ras_ovf, ras_unf;

   pc_branch_unit #(.ADDR_W(ADDR_W), .IMM_W(IMM_W), .RAS_DEPTH(RAS_DEPTH)) dut (
      .clk(clk), .reset(reset), .step(step), .br_valid(br_valid), .br_kind(br_kind),
      .cond(cond), .N(N), .V(V), .Z(Z), .imm(imm), .reg_target(reg_target),
      .clr_flags(clr_flags), .pc(pc), .link(link), .ready(ready), .done(done),
      .taken(taken), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   typedef struct {
      int pc;
      int link;
      int taken;
      int ovf;
      int unf;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // reference state
   int   m_pc, m_link, m_ovf, m_unf;
   int   m_stk[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic bit cond_true(input logic [2:0] c, input bit n, input bit v, input bit z);
      case (c)
         3'd0:    return 1'b1;
         3'd1:    return z;
         3'd2:    return !z;
         3'd3:    return n != v;
         3'd4:    return z || (n != v);
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_pc = 0; m_link = 0; m_ovf = 0; m_unf = 0;
      m_stk.delete();
   endtask

   task automatic model_push(input int val);
      if (RAS) begin
         m_stk.push_back(val);
         if (m_stk.size() > RAS_DEPTH) begin
            void'(m_stk.pop_front());
            m_ovf = 1;
         end
      end
   endtask

   task automatic model_step(input bit bv, input logic [1:0] k, input logic [2:0] c,
                             input bit n, input bit v, input bit z,
                             input logic [IMM_W-1:0] im, input logic [ADDR_W-1:0] rt,
                             input bit clr, output exp_t e);
      int seqv, relv, npc, tk;
      seqv = (m_pc + 1) & MASK;
      relv = (m_pc + 1 + int'($signed(im))) & MASK;
      if (clr) begin m_ovf = 0; m_unf = 0; end
      npc = seqv;
      tk  = 0;
      if (bv) begin
         case (k)
            2'd0: if (cond_true(c, n, v, z)) begin npc = relv; tk = 1; end
            2'd1: begin m_link = seqv; model_push(seqv); npc = relv; tk = 1; end
            2'd3: begin m_link = seqv; model_push(seqv); npc = int'(rt); tk = 1; end
            default: begin
               tk = 1;
               if (RAS && m_stk.size() > 0) npc = m_stk.pop_back();
               else begin
                  npc = int'(rt);
                  if (RAS) m_unf = 1;
               end
            end
         endcase
      end
      m_pc   = npc;
      e.pc   = m_pc;
      e.link = m_link;
      e.taken = tk;
      e.ovf  = m_ovf;
      e.unf  = m_unf;
      e.cyc  = 0;
   endtask

   // monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("pc", int'(pc), e.pc);
            check("link", int'(link), e.link);
            check("taken", int'(taken), e.taken);
            check("ras_ovf", int'(ras_ovf), e.ovf);
            check("ras_unf", int'(ras_unf), e.unf);
         end
      end
   end

   task automatic chk_reset_state();
      check("rst_pc", int'(pc), 0);
      check("rst_link", int'(link), 0);
      check("rst_ready", int'(ready), 1);
      check("rst_done", int'(done), 0);
      check("rst_taken", int'(taken), 0);
      check("rst_ovf", int'(ras_ovf), 0);
      check("rst_unf", int'(ras_unf), 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_state();
      model_reset();
      exp_q.delete();
      reset = 1'b1;
   endtask

   task automatic wait_ready();
      @(negedge clk);
      for (int i = 0; i < 50 && ready !== 1'b1; i++) @(negedge clk);
      if (ready !== 1'b1) check("ready_timeout", int'(ready), 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      check("drain_outstanding", exp_q.size(), 0);
   endtask

   task automatic do_op(input bit bv, input logic [1:0] k, input logic [2:0] c,
                        input bit n, input bit v, input bit z,
                        input logic [IMM_W-1:0] im, input logic [ADDR_W-1:0] rt,
                        input bit clr, input bit bogus, input bit abort);
      exp_t e;
      wait_ready();
      br_valid = bv; br_kind = k; cond = c; N = n; V = v; Z = z;
      imm = im; reg_target = rt; clr_flags = clr; step = 1'b1;
      model_step(bv, k, c, n, v, z, im, rt, clr, e);
      @(posedge clk);
      #1;
      step = 1'b0;
      if (abort) begin
         reset = 1'b0;
         clr_flags = 1'b0;
         repeat (2) @(negedge clk);
         chk_reset_state();
         model_reset();
         exp_q.delete();
         reset = 1'b1;
         repeat (3) @(negedge clk);
         check("abort_no_done", exp_q.size(), 0);
         return;
      end
      check("ready_busy", int'(ready), 0);
      e.cyc = cyc + 2;
      exp_q.push_back(e);
      step       = bogus;
      br_valid   = 1'($urandom);
      br_kind    = 2'($urandom);
      cond       = 3'($urandom);
      {N, V, Z}  = 3'($urandom);
      imm        = IMM_W'($urandom);
      reg_target = ADDR_W'($urandom);
      repeat (2) @(posedge clk);
      #1;
      step = 1'b0;
      clr_flags = 1'b0;
      check("ready_in_done", int'(ready), 0);
      @(posedge clk);
      #1;
      check("ready_back", int'(ready), 1);
   endtask

   task automatic idle_clear();
      wait_ready();
      clr_flags = 1'b1;
      @(posedge clk);
      #1;
      clr_flags = 1'b0;
      m_ovf = 0; m_unf = 0;
      check("clr_ovf", int'(ras_ovf), 0);
      check("clr_unf", int'(ras_unf), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      reset = 1'b0; step = 1'b0; br_valid = 1'b0; br_kind = 2'd0; cond = 3'd0;
      N = 1'b0; V = 1'b0; Z = 1'b0; imm = '0; reg_target = '0; clr_flags = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_reset_state();
      reset = 1'b1;

      // conditional branches
      do_op(1, 2'd0, 3'd0, 0, 0, 0, 8'd4,   9'd0, 0, 0, 0);   // pc 5
      do_op(1, 2'd0, 3'd1, 0, 0, 1, 8'hFD,  9'd0, 0, 1, 0);   // BEQ taken -> 3
      drain();
      check("beq_taken_pc", int'(pc), 3);
      do_op(1, 2'd0, 3'd0, 0, 0, 0, 8'd1,   9'd0, 0, 0, 0);   // pc 5
      do_op(1, 2'd0, 3'd1, 0, 0, 0, 8'hFD,  9'd0, 0, 0, 0);   // BEQ not taken -> 6
      drain();
      check("beq_fall_pc", int'(pc), 6);
      do_op(1, 2'd0, 3'd3, 1, 0, 0, 8'd2,   9'd0, 0, 0, 0);   // BLT taken -> 9
      // wrap-around
      do_op(1, 2'd3, 3'd0, 0, 0, 0, 8'd0,   9'd511, 0, 0, 0); // BLX -> 511
      do_op(0, 2'd0, 3'd0, 0, 0, 0, 8'd0,   9'd0, 0, 1, 0);   // seq -> 0
      drain();
      check("wrap_seq_pc", int'(pc), 0);
      do_op(1, 2'd0, 3'd0, 0, 0, 0, 8'd1,   9'd0, 0, 0, 0);   // pc 2
      do_op(1, 2'd0, 3'd0, 0, 0, 0, 8'h80,  9'd0, 0, 0, 0);   // -> 0x183
      drain();
      check("wrap_rel_pc", int'(pc), 'h183);

      // call / return
      apply_reset();
      do_op(1, 2'd0, 3'd0, 0, 0, 0, 8'd9,   9'd0, 0, 0, 0);   // pc 10
      do_op(1, 2'd1, 3'd0, 0, 0, 0, 8'd20,  9'd0, 0, 0, 0);   // BL -> 31
      drain();
      check("bl_pc", int'(pc), 31);
      check("bl_link", int'(link), 11);
      do_op(1, 2'd2, 3'd0, 0, 0, 0, 8'd0,   9'h0AA, 0, 0, 0); // BX
      drain();
      check("bx_pc", int'(pc), RAS ? 11 : 'h0AA);
      check("bx_unf", int'(ras_unf), 0);

      // stack limits
      apply_reset();
      for (int p = 0; p < 5; p++) do_op(1, 2'd1, 3'd0, 0, 0, 0, 8'd0, 9'd0, 0, 0, 0);
      drain();
      check("five_bl_ovf", int'(ras_ovf), int'(RAS));
      for (int p = 0; p < 5; p++) do_op(1, 2'd2, 3'd0, 0, 0, 0, 8'd0, 9'h040, 0, 0, 0);
      drain();
      check("fifth_bx_pc", int'(pc), 'h040);
      check("fifth_bx_unf", int'(ras_unf), int'(RAS));
      idle_clear();

      // overflow event coinciding with clr_flags: set wins, unf is cleared
      apply_reset();
      do_op(1, 2'd2, 3'd0, 0, 0, 0, 8'd0, 9'h010, 0, 0, 0);   // underflow
      for (int p = 0; p < 4; p++) do_op(1, 2'd1, 3'd0, 0, 0, 0, 8'd3, 9'd0, 0, 0, 0);
      do_op(1, 2'd1, 3'd0, 0, 0, 0, 8'd3, 9'd0, 1, 0, 0);
      drain();
      check("clr_vs_set_ovf", int'(ras_ovf), int'(RAS));
      check("clr_vs_set_unf", int'(ras_unf), 0);

      // reset while resolving
      do_op(1, 2'd1, 3'd0, 0, 0, 0, 8'd7, 9'd0, 0, 0, 1);
      check("abort_pc", int'(pc), 0);

      // random traffic
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 60) == 0) apply_reset();
         else if ($urandom_range(0, 30) == 0) idle_clear();
         do_op(1'($urandom_range(0, 5) != 0), 2'($urandom), 3'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom),
               IMM_W'($urandom), ADDR_W'($urandom),
               $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 1'b0);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
